// File: rtl/addsub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// addsub_seq_ctrl
// Multi-cycle wide add/subtract sequencer. A single shared 8-bit add/sub
// slice processes one byte per clock, least significant byte first, with
// the inter-slice carry held in a register. Operand width is 8*WORDS.
//
// Optional feature (compile-time macro ADDSUB_SAT_EN):
//   defined   -> on signed overflow the result is replaced by signed
//                saturation when the operation completes.
//   undefined -> the wrapped (modulo 2^(8*WORDS)) result is always delivered.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request pulse, sampled only in IDLE
//   sub     in   0 = a+b, 1 = a-b; latched on an accepted start
//   a, b    in   8*WORDS operands; latched on an accepted start
//   busy    out  high from the cycle after an accepted start until done
//   done    out  one-cycle pulse when result/cout/ovf are valid
//   result  out  8*WORDS sum or difference, held until the next accepted start
//   cout    out  carry out of the MSB slice (subtract: 1 = no borrow)
//   ovf     out  signed two's-complement overflow
// ---------------------------------------------------------------------------
module addsub_seq_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int unsigned W     = 8 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic               c_q, c_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Shared slice signals
    logic [7:0]         a_byte_c;
    logic [7:0]         b_byte_c;
    logic [7:0]         b_eff_c;
    logic [8:0]         sum_c;
    logic [7:0]         s_byte_c;
    logic               c_next_c;
    logic               ovf_next_c;
    logic               last_c;

    // Byte select for the current slice index
    always_comb begin
        a_byte_c = 8'h00;
        b_byte_c = 8'h00;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte_c = a_q[8*i +: 8];
                b_byte_c = b_q[8*i +: 8];
            end
        end
    end

    // 8-bit add/sub slice; subtract mode inverts b, the initial carry supplies +1
    always_comb begin
        b_eff_c    = b_byte_c ^ {8{sub_q}};
        sum_c      = {1'b0, a_byte_c} + {1'b0, b_eff_c} + {8'h00, c_q};
        s_byte_c   = sum_c[7:0];
        c_next_c   = sum_c[8];
        // Only meaningful on the MSB slice
        ovf_next_c = (a_byte_c[7] == b_eff_c[7]) && (s_byte_c[7] != a_byte_c[7]);
        last_c     = (idx_q == IDX_W'(WORDS - 1));
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        c_d      = c_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    c_d     = sub;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[8*i +: 8] = s_byte_c;
                    end
                end
                c_d   = c_next_c;
                idx_d = idx_q + IDX_W'(1);
                if (last_c) begin
                    // Index parks at zero so it never wraps past the last slice
                    idx_d   = '0;
                    cout_d  = c_next_c;
                    ovf_d   = ovf_next_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef ADDSUB_SAT_EN
                    // Saturate toward the sign of a (both operands share it on overflow)
                    if (ovf_next_c) begin
                        if (a_byte_c[7]) begin
                            result_d = {1'b1, {(W-1){1'b0}}};
                        end else begin
                            result_d = {1'b0, {(W-1){1'b1}}};
                        end
                    end
`endif
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (WORDS=4): directed vector table,
// hand-written multi-cycle corner sequences and randomized operations checked
// against a plain-arithmetic reference model.
module tb_addsub_seq_ctrl;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;
    localparam int          LIMIT = 50;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           sub;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout;
    logic           ovf;

    int n_chk  = 0;
    int n_fail = 0;

    addsub_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] eres;
        logic         ecout;
        logic         eovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole operand
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, output logic [W-1:0] r,
                                  output logic c, output logic o);
        longint ua, ub, sa, sb, sr, smax, smin;
        ua   = longint'({32'h0, ma});
        ub   = longint'({32'h0, mb});
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (ms) begin
            r  = ma - mb;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ma + mb;
            c  = ((ua + ub) >>> W) != 0;
            sr = sa + sb;
        end
        o = (sr > smax) || (sr < smin);
`ifdef ADDSUB_SAT_EN
        if (o) r = (sr > 0) ? W'(smax) : W'(smin);
`endif
    endfunction

    // Issue one operation and wait for done; lat = cycles after the accept edge
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                          output int lat, output logic busy_seen);
        @(negedge clk);
        a = ta; b = tbv; sub = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        lat = 1;
        while (!done && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[7];
    int          lat;
    logic        bsy;
    logic [W-1:0] er;
    logic        ec, eo;
    logic [W-1:0] held;
    int          dcnt;

    initial begin
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'h00000100, 32'h00000001, 1'b1, 32'h000000FF, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b1};
`else
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
`endif
        vecs[5] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   64'(busy),   64'(0));
        check("reset_done",   64'(done),   64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_cout",   64'(cout),   64'(0));
        check("reset_ovf",    64'(ovf),    64'(0));
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat, bsy);
            check($sformatf("vec%0d_busy", i),    64'(bsy),    64'(1));
            check($sformatf("vec%0d_latency", i), 64'(lat),    64'(WORDS + 1));
            check($sformatf("vec%0d_result", i),  64'(result), 64'(vecs[i].eres));
            check($sformatf("vec%0d_cout", i),    64'(cout),   64'(vecs[i].ecout));
            check($sformatf("vec%0d_ovf", i),     64'(ovf),    64'(vecs[i].eovf));
            check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'(0));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 64'(done), 64'(0));
        end

        // Start while busy: second request two cycles after the first is ignored
        model(32'h0000A5A5, 32'h00001111, 1'b0, er, ec, eo);
        @(negedge clk);
        a = 32'h0000A5A5; b = 32'h00001111; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        dcnt = 0;
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01234567; sub = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                dcnt++;
                check("busy_ign_result", 64'(result), 64'(er));
                // start during the done cycle must also be ignored
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_ign_done_count", 64'(dcnt), 64'(1));
        check("busy_ign_idle_after", 64'(busy), 64'(0));
        held = result;
        repeat (3) @(negedge clk);
        check("result_held", 64'(result), 64'(held));

        // Reset during RUN at slice index 2
        @(negedge clk);
        a = 32'h11223344; b = 32'h01010101; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   64'(busy),   64'(0));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_done",   64'(done),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(dcnt), 64'(0));
        model(32'h11223344, 32'h01010101, 1'b0, er, ec, eo);
        run_op(32'h11223344, 32'h01010101, 1'b0, lat, bsy);
        check("postrst_latency", 64'(lat),    64'(WORDS + 1));
        check("postrst_result",  64'(result), 64'(er));

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            if ((i % 4) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
            model(ra, rb, rs, er, ec, eo);
            run_op(ra, rb, rs, lat, bsy);
            check($sformatf("rnd%0d_latency", i), 64'(lat),    64'(WORDS + 1));
            check($sformatf("rnd%0d_result", i),  64'(result), 64'(er));
            check($sformatf("rnd%0d_cout", i),    64'(cout),   64'(ec));
            check($sformatf("rnd%0d_ovf", i),     64'(ovf),    64'(eo));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
